// File: rtl/btn_pkg.sv
// Shared constants and types for the push-button conditioning front end.
package btn_pkg;

  localparam int BTN_L = 0;
  localparam int BTN_R = 1;
  localparam int BTN_C = 2;

  // 100 MHz board defaults: 10 ms debounce, repeat disabled, 250 ms repeat period
  localparam int N_BTN_DEF           = 3;
  localparam int DEBOUNCE_CYCLES_DEF = 1_000_000;
  localparam int REPEAT_DELAY_DEF    = 0;
  localparam int REPEAT_PERIOD_DEF   = 25_000_000;

  typedef enum logic [1:0] {IDLE, HOLD, REPEAT} rep_state_t;

  // The repeat timer only has to reach max(delay, period) - 1
  function automatic int timer_w(input int delay, input int period);
    int m;
    m = (delay > period) ? delay : period;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/btn_channel.sv
// One button: two-flop synchroniser, debounce, press-edge detect and hold-to-repeat.
module btn_channel
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
  parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TW = timer_w(REPEAT_DELAY, REPEAT_PERIOD);
  localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] DLY_LAST = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] PER_LAST = TW'(REPEAT_PERIOD - 1);
  localparam bit REPEAT_EN = (REPEAT_DELAY != 0);

  logic          sync_p0;
  logic          sync_p1;
  logic          stable;
  logic [CW-1:0] cnt;

  // Stage p0/p1: synchroniser; stable flips after DEBOUNCE_CYCLES consecutive mismatches
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      stable  <= 1'b0;
      cnt     <= '0;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
      if (sync_p1 == stable) begin
        cnt <= '0;
      end else if (cnt == DB_LAST) begin
        stable <= ~stable;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  rep_state_t    state;
  logic [TW-1:0] timer;
  logic          press;
  logic          fall;

  assign press = stable & ~level;
  assign fall  = ~stable & level;

  // Output stage: registered level, press strobe and repeat FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      timer <= '0;
      level <= 1'b0;
      pulse <= 1'b0;
    end else begin
      level <= stable;
      pulse <= press;
      if (REPEAT_EN) begin
        case (state)
          IDLE: begin
            if (press) begin
              state <= HOLD;
              timer <= '0;
            end
          end
          HOLD: begin
            if (fall) begin
              state <= IDLE;
              timer <= '0;
            end else if (timer == DLY_LAST) begin
              pulse <= 1'b1;
              state <= REPEAT;
              timer <= '0;
            end else begin
              timer <= timer + TW'(1);
            end
          end
          REPEAT: begin
            if (fall) begin
              state <= IDLE;
              timer <= '0;
            end else if (timer == PER_LAST) begin
              pulse <= 1'b1;
              timer <= '0;
            end else begin
              timer <= timer + TW'(1);
            end
          end
          default: begin
            state <= IDLE;
            timer <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/btn_conditioner.sv
// Conditions N_BTN raw push-buttons into debounced levels and single-cycle press pulses.
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int N_BTN           = N_BTN_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
  parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_pulse
);

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_ch (
      .clk  (clk),
      .reset(reset),
      .raw  (btn_raw[i]),
      .level(btn_level[i]),
      .pulse(btn_pulse[i])
    );
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner: one instance without repeat, one with repeat, sharing the raw inputs.
module tb_btn_conditioner;

  localparam int D  = 4;
  localparam int RD = 10;
  localparam int RP = 5;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] raw   = '0;
  logic [2:0] level0, pulse0, level1, pulse1;

  int checks   = 0;
  int failures = 0;

  // Reference model: history of raw samples since reset and the derived outputs
  logic [2:0] rawh[$];
  logic [2:0] mstable = '0;
  logic [2:0] mlev    = '0;
  logic [2:0] mpls0   = '0;
  logic [2:0] mpls1   = '0;
  int         hold[3] = '{-1, -1, -1};

  btn_conditioner #(.N_BTN(3), .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(0), .REPEAT_PERIOD(1)) dut0 (
    .clk(clk), .reset(reset), .btn_raw(raw), .btn_level(level0), .btn_pulse(pulse0)
  );

  btn_conditioner #(.N_BTN(3), .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut1 (
    .clk(clk), .reset(reset), .btn_raw(raw), .btn_level(level1), .btn_pulse(pulse1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    rawh.delete();
    mstable = '0;
    mlev    = '0;
    mpls0   = '0;
    mpls1   = '0;
    for (int c = 0; c < 3; c++) hold[c] = -1;
  endtask

  // Value the debounce logic sees at edge idx: the raw sample from two edges earlier
  function automatic logic dbin(input int idx, input int c);
    logic [2:0] v;
    if (idx < 2) return 1'b0;
    v = rawh[idx-2];
    return v[c];
  endfunction

  task automatic model_edge();
    logic [2:0] nl, nst;
    int  k;
    bit  flip;
    rawh.push_back(raw);
    k   = rawh.size() - 1;
    nl  = mstable;
    nst = mstable;
    for (int c = 0; c < 3; c++) begin
      flip = (k >= D - 1);
      for (int j = 0; j < D; j++) if (dbin(k - j, c) == mstable[c]) flip = 0;
      if (flip) nst[c] = ~mstable[c];
    end
    mpls0 = nl & ~mlev;
    mpls1 = mpls0;
    for (int c = 0; c < 3; c++) begin
      if (mpls0[c]) begin
        hold[c] = 0;
      end else if (nl[c] && mlev[c] && hold[c] >= 0) begin
        hold[c]++;
        if (hold[c] >= RD && (hold[c] - RD) % RP == 0) mpls1[c] = 1'b1;
      end else begin
        hold[c] = -1;
      end
    end
    mlev    = nl;
    mstable = nst;
  endtask

  task automatic step();
    @(posedge clk);
    if (!reset) model_edge();
    #1;
    chk("level0", 32'(level0), 32'(mlev));
    chk("pulse0", 32'(pulse0), 32'(mpls0));
    chk("level1", 32'(level1), 32'(mlev));
    chk("pulse1", 32'(pulse1), 32'(mpls1));
  endtask

  task automatic settle();
    raw = '0;
    repeat (12) step();
  endtask

  initial begin
    int first;
    int cnt;
    int pc[3];
    int fe[3];
    int pe[$];
    int rep_exp[6];
    int left[3];
    logic [5:0] pat;
    logic [2:0] seen;

    // Reset with every button held
    raw = 3'b111;
    reset = 1'b1;
    model_reset();
    repeat (3) step();
    chk("rst_level", 32'({level1, level0}), 0);
    chk("rst_pulse", 32'({pulse1, pulse0}), 0);
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin pc[c] = 0; fe[c] = -1; end
    for (int i = 0; i < 12; i++) begin
      step();
      for (int c = 0; c < 3; c++) if (pulse0[c]) begin
        pc[c]++;
        if (fe[c] < 0) fe[c] = i;
      end
    end
    for (int c = 0; c < 3; c++) begin
      chk("rst_release_pulse_cnt", pc[c], 1);
      chk("rst_release_pulse_edge", fe[c], 6);
    end
    settle();

    // Clean press and release on L
    raw = 3'b001;
    first = -1; cnt = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (level0[0] && first < 0) first = i;
      if (pulse0[0]) cnt++;
    end
    chk("press_latency", first, 6);
    chk("press_pulses", cnt, 1);
    raw = 3'b000;
    first = -1; cnt = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (!level0[0] && first < 0) first = i;
      if (pulse0[0]) cnt++;
    end
    chk("release_latency", first, 6);
    chk("release_pulses", cnt, 0);
    settle();

    // Bounce on R: 1,0,1,1,0,1 then held high
    pat = 6'b101101;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      raw[1] = pat[i];
      step();
      if (pulse0[1]) cnt++;
    end
    chk("bounce_no_pulse", cnt, 0);
    first = -1;
    for (int i = 0; i < 12; i++) begin
      step();
      if (pulse0[1]) begin
        cnt++;
        if (first < 0) first = i;
      end
    end
    chk("bounce_pulse_cnt", cnt, 1);
    chk("bounce_pulse_edge", first, 5);
    settle();

    // Simultaneous L and R
    raw = 3'b011;
    cnt = 0; seen = '0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (pulse0 != 3'b000) begin
        cnt++;
        if (seen == 3'b000) seen = pulse0;
      end
    end
    chk("simul_pulse_vec", 32'(seen), 3);
    chk("simul_pulse_cycles", cnt, 1);
    settle();

    // Hold C for 40 cycles on the repeating instance
    rep_exp = '{6, 16, 21, 26, 31, 36};
    raw = 3'b100;
    pe.delete();
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (pulse1[2]) pe.push_back(i);
      if (pulse0[2]) cnt++;
    end
    chk("rep_count", pe.size(), 6);
    for (int j = 0; j < 6; j++) chk("rep_edge", (j < pe.size()) ? pe[j] : -1, rep_exp[j]);
    chk("norep_count", cnt, 1);
    raw = 3'b000;
    cnt = 0; first = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (pulse1[2]) cnt++;
      if (pulse1[2] && !level1[2]) first++;
    end
    chk("rep_release_pulses", cnt, 1);
    chk("rep_pulse_after_fall", first, 0);
    settle();

    // Reset while repeating, button still held
    raw = 3'b100;
    repeat (25) step();
    reset = 1'b1;
    model_reset();
    #1;
    chk("midrst_level", 32'({level1, level0}), 0);
    chk("midrst_pulse", 32'({pulse1, pulse0}), 0);
    repeat (2) step();
    reset = 1'b0;
    pe.delete();
    for (int i = 0; i < 20; i++) begin
      step();
      if (pulse1[2]) pe.push_back(i);
    end
    chk("midrst_count", pe.size(), 2);
    chk("midrst_press_edge", (pe.size() > 0) ? pe[0] : -1, 6);
    chk("midrst_repeat_edge", (pe.size() > 1) ? pe[1] : -1, 16);
    settle();

    // Random bouncing on all channels, with one reset in the middle
    for (int c = 0; c < 3; c++) left[c] = $urandom_range(1, 9);
    for (int n = 0; n < 1500; n++) begin
      for (int c = 0; c < 3; c++) begin
        left[c]--;
        if (left[c] <= 0) begin
          raw[c] = ~raw[c];
          left[c] = $urandom_range(1, 12);
        end
      end
      if (n == 700) begin
        reset = 1'b1;
        model_reset();
        step();
        reset = 1'b0;
      end else begin
        step();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
